// File: rtl/serial_bit_tx.sv
// Parallel-in, serial-out bit transmitter: shifts a WIDTH-bit word out on D, one bit
// per Clk cycle, qualified by Frame, with a Done pulse on the last bit of each word.
module serial_bit_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Load_data,
    input  logic             Load_valid,
    output logic             Load_ready,
    output logic             D,
    output logic             Frame,
    output logic             Done,
    output logic             Dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             d_n, frame_n, done_n;
    logic             last, accept;

    // Handshake: a word transfers on a rising edge where Load_valid && Load_ready.
    // Load_ready depends only on registered state, so the source may hold Load_valid
    // and Load_data until the transfer; nothing is sampled while Load_ready is low.
    always_comb begin
        last       = (state == SHIFT) && (cnt == LAST);
        Load_ready = (state == IDLE) || last;
        accept     = Load_valid && Load_ready;

        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        d_n     = D;
        frame_n = Frame;

        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            frame_n = 1'b1;
            if (MSB_FIRST) begin
                d_n     = Load_data[WIDTH-1];
                shreg_n = Load_data << 1;
            end else begin
                d_n     = Load_data[0];
                shreg_n = Load_data >> 1;
            end
        end else if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
            shreg_n = '0;
            d_n     = IDLE_LEVEL;
            frame_n = 1'b0;
        end else if (state == SHIFT) begin
            // shreg holds only the bits not yet placed on D
            cnt_n = cnt + 1'b1;
            if (MSB_FIRST) begin
                d_n     = shreg[WIDTH-1];
                shreg_n = shreg << 1;
            end else begin
                d_n     = shreg[0];
                shreg_n = shreg >> 1;
            end
        end

        done_n = frame_n && (cnt_n == LAST);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            D     <= IDLE_LEVEL;
            Frame <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            D     <= d_n;
            Frame <= frame_n;
            Done  <= done_n;
        end
    end

    assign Dbg_state = state;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: an MSB-first and an LSB-first instance share
// clock and reset; every expected bit stream is a hand-written constant.
module tb_serial_bit_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, l_ready;
    logic       m_d, l_d;
    logic       m_frame, l_frame;
    logic       m_done, l_done;
    logic       m_state, l_state;
    logic       qp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External capture flop fed from the serial line
    always @(posedge clk) qp <= m_d;

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .Clk(clk), .Reset(reset), .Load_data(m_data), .Load_valid(m_valid),
        .Load_ready(m_ready), .D(m_d), .Frame(m_frame), .Done(m_done),
        .Dbg_state(m_state)
    );

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .Clk(clk), .Reset(reset), .Load_data(l_data), .Load_valid(l_valid),
        .Load_ready(l_ready), .D(l_d), .Frame(l_frame), .Done(l_done),
        .Dbg_state(l_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks += 5;
        if (m_d !== 1'b0)     begin failures++; $display("FAIL reset_d got=%b exp=0", m_d); end
        if (m_frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", m_frame); end
        if (m_done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", m_done); end
        if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", m_ready); end
        if (l_frame !== 1'b0 || l_d !== 1'b0 || l_ready !== 1'b1) begin
            failures++; $display("FAIL reset_lsb d=%b frame=%b ready=%b exp d=0 frame=0 ready=1", l_d, l_frame, l_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b00000001;
        m_data = 8'h01; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_data = 'x;
        for (int c = 1; c <= 8; c++) begin
            checks += 4;
            if (m_d !== exp_bits[8-c]) begin failures++; $display("FAIL msb_d cycle=%0d got=%b exp=%b", c, m_d, exp_bits[8-c]); end
            if (m_frame !== 1'b1) begin failures++; $display("FAIL msb_frame cycle=%0d got=%b exp=1", c, m_frame); end
            if (m_done !== (c == 8)) begin failures++; $display("FAIL msb_done cycle=%0d got=%b exp=%b", c, m_done, c == 8); end
            if (m_ready !== (c == 8)) begin failures++; $display("FAIL msb_ready cycle=%0d got=%b exp=%b", c, m_ready, c == 8); end
            step();
        end
        checks += 3;
        if (m_d !== 1'b0)     begin failures++; $display("FAIL msb_idle_d got=%b exp=0", m_d); end
        if (m_frame !== 1'b0) begin failures++; $display("FAIL msb_idle_frame got=%b exp=0", m_frame); end
        if (m_state !== 1'b0) begin failures++; $display("FAIL msb_idle_state got=%b exp=0", m_state); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b10000000;
        l_data = 8'h01; l_valid = 1'b1;
        step();
        l_valid = 1'b0; l_data = 'x;
        for (int c = 1; c <= 8; c++) begin
            checks += 3;
            if (l_d !== exp_bits[8-c]) begin failures++; $display("FAIL lsb_d cycle=%0d got=%b exp=%b", c, l_d, exp_bits[8-c]); end
            if (l_frame !== 1'b1) begin failures++; $display("FAIL lsb_frame cycle=%0d got=%b exp=1", c, l_frame); end
            if (l_done !== (c == 8)) begin failures++; $display("FAIL lsb_done cycle=%0d got=%b exp=%b", c, l_done, c == 8); end
            step();
        end
        checks += 3;
        if (l_d !== 1'b0)     begin failures++; $display("FAIL lsb_idle_d got=%b exp=0", l_d); end
        if (l_frame !== 1'b0) begin failures++; $display("FAIL lsb_idle_frame got=%b exp=0", l_frame); end
        if (l_done !== 1'b0)  begin failures++; $display("FAIL lsb_idle_done got=%b exp=0", l_done); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        exp_bits = 16'b1111000000001111;
        m_data = 8'hF0; m_valid = 1'b1;
        step();
        m_data = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            checks += 3;
            if (m_d !== exp_bits[15-k]) begin failures++; $display("FAIL b2b_d bit=%0d got=%b exp=%b", k, m_d, exp_bits[15-k]); end
            if (m_frame !== 1'b1) begin failures++; $display("FAIL b2b_frame bit=%0d got=%b exp=1", k, m_frame); end
            if (m_done !== (k == 7 || k == 15)) begin failures++; $display("FAIL b2b_done bit=%0d got=%b exp=%b", k, m_done, k == 7 || k == 15); end
            if (k == 8) begin m_valid = 1'b0; m_data = 'x; end
            step();
        end
        checks += 1;
        if (m_frame !== 1'b0 || m_done !== 1'b0) begin
            failures++; $display("FAIL b2b_end frame=%b done=%b exp frame=0 done=0", m_frame, m_done);
        end
    endtask

    task automatic test_busy();
        logic [15:0] exp_bits;
        exp_bits = 16'hFFAA;
        m_data = 8'hFF; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_data = 'x;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin m_data = 8'hAA; m_valid = 1'b1; end
            checks += 4;
            if (m_d !== exp_bits[15-k]) begin failures++; $display("FAIL busy_d bit=%0d got=%b exp=%b", k, m_d, exp_bits[15-k]); end
            if (m_frame !== 1'b1) begin failures++; $display("FAIL busy_frame bit=%0d got=%b exp=1", k, m_frame); end
            if (m_done !== (k == 7 || k == 15)) begin failures++; $display("FAIL busy_done bit=%0d got=%b exp=%b", k, m_done, k == 7 || k == 15); end
            if (m_ready !== (k == 7 || k == 15)) begin failures++; $display("FAIL busy_ready bit=%0d got=%b exp=%b", k, m_ready, k == 7 || k == 15); end
            if (k == 8) begin m_valid = 1'b0; m_data = 'x; end
            step();
        end
        checks += 1;
        if (m_frame !== 1'b0) begin failures++; $display("FAIL busy_end_frame got=%b exp=0", m_frame); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] first_bits, next_bits;
        logic       exp_q;
        first_bits = 8'hC3;
        next_bits  = 8'h81;
        m_data = first_bits; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_data = 'x;
        for (int c = 1; c <= 4; c++) begin
            checks += 1;
            if (m_d !== first_bits[8-c]) begin failures++; $display("FAIL abort_d cycle=%0d got=%b exp=%b", c, m_d, first_bits[8-c]); end
            if (c < 4) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 4;
        if (m_d !== 1'b0)     begin failures++; $display("FAIL abort_rst_d got=%b exp=0", m_d); end
        if (m_frame !== 1'b0) begin failures++; $display("FAIL abort_rst_frame got=%b exp=0", m_frame); end
        if (m_done !== 1'b0)  begin failures++; $display("FAIL abort_rst_done got=%b exp=0", m_done); end
        if (m_ready !== 1'b1) begin failures++; $display("FAIL abort_rst_ready got=%b exp=1", m_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks += 1;
            if (m_frame !== 1'b0 || m_done !== 1'b0 || m_d !== 1'b0) begin
                failures++; $display("FAIL abort_no_resume cycle=%0d d=%b frame=%b done=%b exp all 0", c, m_d, m_frame, m_done);
            end
        end
        m_data = next_bits; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_data = 'x;
        for (int c = 1; c <= 8; c++) begin
            exp_q = (c == 1) ? 1'b0 : next_bits[9-c];
            checks += 3;
            if (m_d !== next_bits[8-c]) begin failures++; $display("FAIL post_d cycle=%0d got=%b exp=%b", c, m_d, next_bits[8-c]); end
            if (m_done !== (c == 8)) begin failures++; $display("FAIL post_done cycle=%0d got=%b exp=%b", c, m_done, c == 8); end
            if (qp !== exp_q) begin failures++; $display("FAIL qp_follow cycle=%0d got=%b exp=%b", c, qp, exp_q); end
            step();
        end
        checks += 2;
        if (qp !== next_bits[0]) begin failures++; $display("FAIL qp_last got=%b exp=%b", qp, next_bits[0]); end
        if (m_frame !== 1'b0)    begin failures++; $display("FAIL post_end_frame got=%b exp=0", m_frame); end
    endtask

    initial begin
        reset   = 1'b1;
        m_data  = '0; m_valid = 1'b0;
        l_data  = '0; l_valid = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
